// File: rtl/sensor_frontend.sv
// Sensor front end: synchronizes and debounces the contact/alarm lines and
// turns the temperature sample stream into the 2-bit ST climate code.
module sensor_frontend #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int FA_ASSERT_CYCLES = 2,
  parameter int T_LOW            = 18,
  parameter int T_HIGH           = 30,
  parameter int HYST             = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_w,
  input  logic       raw_fa,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [1:0] ST,
  output logic       change
);

  localparam int CW = (DEBOUNCE_CYCLES > 8) ? $clog2(DEBOUNCE_CYCLES) : 3;
  localparam logic [CW-1:0] LIM_DB    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LIM_FA_ON = CW'(FA_ASSERT_CYCLES - 1);

  localparam logic [7:0] TH_LOW     = 8'(T_LOW);
  localparam logic [7:0] TH_HIGH    = 8'(T_HIGH);
  localparam logic [7:0] TH_LOW_UP  = 8'(T_LOW + HYST);
  localparam logic [7:0] TH_HIGH_DN = 8'(T_HIGH - HYST);

  localparam logic [1:0] ST_COMFORT = 2'b00;
  localparam logic [1:0] ST_COLD    = 2'b01;
  localparam logic [1:0] ST_HOT     = 2'b11;

  // Channel index: 0 front door, 1 rear door, 2 window, 3 fire alarm.
  logic [3:0]          raw_vec;
  logic [3:0]          s1_q, s2_q;
  logic [3:0]          deb_q, deb_d;
  logic [3:0][CW-1:0]  cnt_q, cnt_d;
  logic [3:0][CW-1:0]  lim;
  logic [1:0]          st_q, st_d;
  logic                change_q, change_d;

  assign raw_vec = {raw_fa, raw_w, raw_rd, raw_fd};

  // Fire asserts after FA_ASSERT_CYCLES samples but clears only after the
  // full debounce window, so an alarm is reported fast and dropped slowly.
  always_comb begin
    lim[0] = LIM_DB;
    lim[1] = LIM_DB;
    lim[2] = LIM_DB;
    lim[3] = deb_q[3] ? LIM_DB : LIM_FA_ON;
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == lim[i]) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // temp_valid is a valid-only qualifier (no ready): the sample is consumed
  // on every edge where it is high; the encoding 2'b10 falls into COMFORT.
  always_comb begin
    st_d = st_q;
    if (temp_valid) begin
      case (st_q)
        ST_COLD: begin
          if (temp_in > TH_HIGH)         st_d = ST_HOT;
          else if (temp_in >= TH_LOW_UP) st_d = ST_COMFORT;
          else                           st_d = ST_COLD;
        end
        ST_HOT: begin
          if (temp_in < TH_LOW)           st_d = ST_COLD;
          else if (temp_in <= TH_HIGH_DN) st_d = ST_COMFORT;
          else                            st_d = ST_HOT;
        end
        default: begin
          if (temp_in < TH_LOW)       st_d = ST_COLD;
          else if (temp_in > TH_HIGH) st_d = ST_HOT;
          else                        st_d = ST_COMFORT;
        end
      endcase
    end
  end

  assign change_d = ({deb_d, st_d} != {deb_q, st_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      st_q     <= ST_COMFORT;
      change_q <= 1'b0;
    end else begin
      s1_q     <= raw_vec;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      change_q <= change_d;
    end
  end

  assign SFD    = deb_q[0];
  assign SRD    = deb_q[1];
  assign SW     = deb_q[2];
  assign SFA    = deb_q[3];
  assign ST     = st_q;
  assign change = change_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed, table-driven bench for sensor_frontend: one record per clock edge
// holding the inputs driven before the edge and the outputs expected after it.
module tb_sensor_frontend;

  logic       clk;
  logic       rst;
  logic       raw_fd, raw_rd, raw_w, raw_fa;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic       SFD, SRD, SW, SFA;
  logic [1:0] ST;
  logic       change;

  // Expected output word: {SFD, SRD, SW, SFA, ST[1:0], change}
  typedef struct packed {
    logic       rst;
    logic [3:0] raw;   // {fd, rd, w, fa}
    logic [7:0] temp;
    logic       tv;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         n_applied;
  int         n_fail;

  sensor_frontend dut (
    .clk        (clk),
    .rst        (rst),
    .raw_fd     (raw_fd),
    .raw_rd     (raw_rd),
    .raw_w      (raw_w),
    .raw_fa     (raw_fa),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .SFD        (SFD),
    .SRD        (SRD),
    .SW         (SW),
    .SFA        (SFA),
    .ST         (ST),
    .change     (change)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] dut_word();
    return {SFD, SRD, SW, SFA, ST, change};
  endfunction

  task automatic add(input logic r, input logic [3:0] raw, input int temp,
                     input logic tv, input logic [6:0] exp, input int n);
    vec_t v;
    v.rst  = r;
    v.raw  = raw;
    v.temp = 8'(temp);
    v.tv   = tv;
    v.exp  = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    raw_fd     = v.raw[3];
    raw_rd     = v.raw[2];
    raw_w      = v.raw[1];
    raw_fa     = v.raw[0];
    temp_in    = v.temp;
    temp_valid = v.tv;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = dut_word();
    n_applied++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {SFD,SRD,SW,SFA,ST,change}=%b required %b", name, got, exp);
    end
  endtask

  initial begin
    n_applied  = 0;
    n_fail     = 0;
    rst        = 1'b0;
    raw_fd     = 1'b0;
    raw_rd     = 1'b0;
    raw_w      = 1'b0;
    raw_fa     = 1'b0;
    temp_in    = 8'd0;
    temp_valid = 1'b0;

    // reset then idle
    add(0, 4'b0000, 0, 0, 7'b0000000, 3);
    add(1, 4'b0000, 0, 0, 7'b0000000, 2);
    // front door: rise at edge 6, 3-sample glitch ignored, fall at edge 6
    add(1, 4'b1000, 0, 0, 7'b0000000, 5);
    add(1, 4'b1000, 0, 0, 7'b1000001, 1);
    add(1, 4'b1000, 0, 0, 7'b1000000, 1);
    add(1, 4'b0000, 0, 0, 7'b1000000, 3);
    add(1, 4'b1000, 0, 0, 7'b1000000, 6);
    add(1, 4'b0000, 0, 0, 7'b1000000, 5);
    add(1, 4'b0000, 0, 0, 7'b0000001, 1);
    add(1, 4'b0000, 0, 0, 7'b0000000, 1);
    // fire alarm: assert at edge 4, clear at edge 6, 1-cycle pulse ignored
    add(1, 4'b0001, 0, 0, 7'b0000000, 3);
    add(1, 4'b0001, 0, 0, 7'b0001001, 1);
    add(1, 4'b0001, 0, 0, 7'b0001000, 2);
    add(1, 4'b0000, 0, 0, 7'b0001000, 5);
    add(1, 4'b0000, 0, 0, 7'b0000001, 1);
    add(1, 4'b0001, 0, 0, 7'b0000000, 1);
    add(1, 4'b0000, 0, 0, 7'b0000000, 5);
    // climate hysteresis 25,17,19,20,31,29,28 then invalid samples
    add(1, 4'b0000, 25, 1, 7'b0000000, 1);
    add(1, 4'b0000, 17, 1, 7'b0000011, 1);
    add(1, 4'b0000, 19, 1, 7'b0000010, 1);
    add(1, 4'b0000, 20, 1, 7'b0000001, 1);
    add(1, 4'b0000, 31, 1, 7'b0000111, 1);
    add(1, 4'b0000, 29, 1, 7'b0000110, 1);
    add(1, 4'b0000, 28, 1, 7'b0000001, 1);
    add(1, 4'b0000,  5, 0, 7'b0000000, 2);
    // direct jumps, holds with temp_valid low, boundaries
    add(1, 4'b0000, 17, 1, 7'b0000011, 1);
    add(1, 4'b0000,  5, 0, 7'b0000010, 1);
    add(1, 4'b0000, 31, 1, 7'b0000111, 1);
    add(1, 4'b0000,  5, 0, 7'b0000110, 1);
    add(1, 4'b0000, 17, 1, 7'b0000011, 1);
    add(1, 4'b0000, 31, 1, 7'b0000111, 1);
    add(1, 4'b0000, 30, 1, 7'b0000110, 1);
    add(1, 4'b0000, 28, 1, 7'b0000001, 1);
    add(1, 4'b0000, 18, 1, 7'b0000000, 1);
    add(1, 4'b0000, 30, 1, 7'b0000000, 1);
    // simultaneous: ST at edge 1, SRD/SW together at edge 6
    add(1, 4'b0110, 10, 1, 7'b0000011, 1);
    add(1, 4'b0110,  0, 0, 7'b0000010, 4);
    add(1, 4'b0110,  0, 0, 7'b0110011, 1);
    add(1, 4'b0110,  0, 0, 7'b0110010, 1);
    add(1, 4'b0000,  0, 0, 7'b0110010, 5);
    add(1, 4'b0000,  0, 0, 7'b0000011, 1);
    // reset at edge 4 aborts the count; fresh 6-edge count after release
    add(1, 4'b0110,  0, 0, 7'b0000010, 3);
    add(0, 4'b0110,  0, 0, 7'b0000000, 1);
    add(1, 4'b0110,  0, 0, 7'b0000000, 5);
    add(1, 4'b0110,  0, 0, 7'b0110001, 1);
    add(1, 4'b0110,  0, 0, 7'b0110000, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // asynchronous reset in the middle of a cycle clears outputs at once
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_mid_cycle", 7'b0000000);
    @(posedge clk);
    #1;
    check("async_rst_held", 7'b0000000);

    // ST hold in HOT with temp_valid low after a fresh start
    @(negedge clk);
    rst = 1'b1;
    raw_rd = 1'b0;
    raw_w  = 1'b0;
    temp_in = 8'd40;
    temp_valid = 1'b1;
    @(posedge clk);
    #1;
    check("hot_from_reset", 7'b0000111);
    @(negedge clk);
    temp_in = 8'd5;
    temp_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hot_hold_invalid", 7'b0000110);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_frontend.md
Name: sensor_frontend

Overview:
Sensor-side front end that produces the sensor bus consumed by the home automation controller: SFD, SRD, SW, SFA and ST[1:0].
- Synchronizes and debounces four raw contact/alarm lines.
- Quantizes an 8-bit temperature sample into the 2-bit ST climate code, using a hysteresis FSM.
- Sits between the board sensor pins/ADC and the automation controller, on the same clk.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to change SFD/SRD/SW, and to deassert SFA (>=1)
FA_ASSERT_CYCLES, 2, consecutive high samples needed to assert SFA (1..DEBOUNCE_CYCLES)
T_LOW, 18, unsigned temperature threshold below which the climate is COLD
T_HIGH, 30, unsigned temperature threshold above which the climate is HOT
HYST, 2, hysteresis margin; requires T_LOW+HYST <= T_HIGH-HYST

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
raw_fd  input  1  raw front-door contact, asynchronous
raw_rd  input  1  raw rear-door contact, asynchronous
raw_w  input  1  raw window contact, asynchronous
raw_fa  input  1  raw fire-alarm detector, asynchronous
temp_in  input  8  unsigned temperature sample, synchronous to clk
temp_valid  input  1  temp_in valid this cycle
SFD  output  1  debounced front-door sensor
SRD  output  1  debounced rear-door sensor
SW  output  1  debounced window sensor
SFA  output  1  filtered fire-alarm sensor
ST  output  2  climate code: 00 comfort, 01 cold, 11 hot; 10 is never driven
change  output  1  one-cycle pulse when any of SFD/SRD/SW/SFA/ST changed

Behaviour:
- Reset (rst=0, asynchronous):
  - SFD=SRD=SW=SFA=0, ST=00, change=0.
  - Synchronizer flops and all counters cleared; climate FSM in COMFORT.
  - Reset asserted mid-debounce or mid-count discards the partial count.
  - Deassertion is synchronized externally; the block starts counting on the first edge after release.
- Synchronizer: each raw line passes through 2 flops (s1, s2); only s2 is used downstream.
- Debounce for SFD/SRD/SW, per channel:
  - 3-bit-min counter cnt.
  - If s2 equals the output, cnt is cleared to 0.
  - If s2 differs and cnt == DEBOUNCE_CYCLES-1: output <= s2, cnt <= 0.
  - Otherwise cnt increments.
  - Latency: a raw change held stable appears on the output at the (2+DEBOUNCE_CYCLES)th rising edge after the change; 6 edges with default parameters.
  - A glitch shorter than DEBOUNCE_CYCLES samples never reaches the output.
- SFA filter: same structure, with asymmetric thresholds.
  - Rising transition requires FA_ASSERT_CYCLES differing samples; default latency 4 edges.
  - Falling transition requires DEBOUNCE_CYCLES differing samples.
  - Fire is reported fast and cleared slowly.
- Climate FSM (states COMFORT=00, COLD=01, HOT=11; ST is the state register):
  - Evaluated only on edges where temp_valid=1; otherwise the state holds. ST updates on that same edge (1-cycle latency).
  - All compares are unsigned 8-bit.
  - From COMFORT:
    - temp_in < T_LOW -> COLD
    - temp_in > T_HIGH -> HOT
    - else stay
  - From COLD:
    - temp_in > T_HIGH -> HOT (direct jump allowed)
    - temp_in >= T_LOW+HYST -> COMFORT
    - else stay
  - From HOT:
    - temp_in < T_LOW -> COLD
    - temp_in <= T_HIGH-HYST -> COMFORT
    - else stay
  - Encoding 10 is unreachable; if ever present, next valid sample treats it as COMFORT.
- change:
  - Registered; high for exactly the one cycle in which the new output values first appear.
  - Simultaneous changes on several outputs give one pulse.
  - Back-to-back changes on consecutive edges keep change high for consecutive cycles.
- Outputs are all registered; no combinational path from any input to any output.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, raw_*=0, temp_valid=0 -> all outputs 0, ST=00, change=0; async assert mid-cycle clears outputs immediately.
2. Debounce: raw_fd 0->1 held -> SFD=1 at the 6th edge, change=1 that cycle only. Then raw_fd pulses low for 3 cycles -> SFD stays 1, no change pulse.
3. Fire asymmetry: raw_fa 0->1 held -> SFA=1 at edge 4. Then raw_fa 1->0 held -> SFA=0 at edge 6. A 1-cycle raw_fa pulse -> SFA stays 0.
4. Climate hysteresis: temp_valid samples 25,17,19,20,31,29,28 -> ST 00,01,01,00,11,11,00. Samples with temp_valid=0 (value 5) leave ST unchanged.
5. Direct jumps and boundaries: from COLD, sample 31 -> ST=11. From HOT, sample 17 -> ST=01. Sample exactly 18 or 30 from COMFORT -> stays 00.
6. Simultaneous events: raw_rd and raw_w change on the same edge as a temp sample causing a COMFORT->COLD move. Result: ST changes at edge 1 with a change pulse, then SRD/SW change together at edge 6 with a single change pulse. rst=0 at edge 4 aborts the debounce, and the outputs stay 0 after release until a fresh 6-edge count.
